// File: rtl/sync_fifo.sv
// Single-clock FIFO of DEPTH x WIDTH words; read data registered, 1-cycle read latency.
// Full/empty reject requests with a one-cycle error pulse; a read on a full FIFO frees room for a same-cycle write.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     write_enable,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     is_empty,
  output logic                     is_full,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     write_error,
  output logic                     read_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic             write_error_q, write_error_d;
  logic             read_error_q, read_error_d;

  logic             rd_acc;
  logic             wr_acc;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  // Status is a function of the pointer registers only, never of this cycle's requests.
  assign is_empty   = (wr_ptr_q == rd_ptr_q);
  assign is_full    = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign fill_count = wr_ptr_q - rd_ptr_q;

  assign rd_acc = read_enable && !is_empty;
  assign wr_acc = write_enable && (!is_full || rd_acc);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    read_data_d   = read_data_q;
    write_error_d = write_enable && !wr_acc;
    read_error_d  = read_enable && !rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      read_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      read_data_q   <= '0;
      write_error_q <= 1'b0;
      read_error_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      read_data_q   <= read_data_d;
      write_error_q <= write_error_d;
      read_error_q  <= read_error_d;
    end
  end

  // Storage is left unreset; when full, a same-edge read still sees the old word here.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr_addr] <= write_data;
    end
  end

  assign read_data   = read_data_q;
  assign write_error = write_error_q;
  assign read_error  = read_error_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo at DEPTH=4: directed sequences, mid-run reset and a random phase.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] write_data;
  logic             write_enable;
  logic             read_enable;
  logic [WIDTH-1:0] read_data;
  logic             is_empty;
  logic             is_full;
  logic [CW-1:0]    fill_count;
  logic             write_error;
  logic             read_error;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .is_empty     (is_empty),
    .is_full      (is_full),
    .fill_count   (fill_count),
    .write_error  (write_error),
    .read_error   (read_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] exp_rd[$];
  logic [WIDTH-1:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_status();
    check_eq("fill_count", 32'(fill_count), 32'(model.size()));
    check_eq("is_empty", 32'(is_empty), 32'(model.size() == 0));
    check_eq("is_full", 32'(is_full), 32'(model.size() == DEPTH));
  endtask

  // One clock of stimulus; expectations are pushed before the edge and popped after it.
  task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re);
    bit rd_ok;
    bit wr_ok;
    rd_ok = re && (model.size() != 0);
    wr_ok = we && ((model.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_rd.push_back(model.pop_front());
    if (wr_ok) model.push_back(wd);
    write_enable = we;
    write_data   = we ? wd : 'x;
    read_enable  = re;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = 'x;
    if (rd_ok) begin
      if (exp_rd.size() == 0) begin
        check_eq("scoreboard_underrun", 32'(exp_rd.size()), 32'd1);
      end else begin
        last_rd = exp_rd.pop_front();
      end
    end
    check_eq("read_data", 32'(read_data), 32'(last_rd));
    check_eq("write_error", 32'(write_error), 32'(we && !wr_ok));
    check_eq("read_error", 32'(read_error), 32'(re && !rd_ok));
    check_status();
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, '0, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_read_data"}, 32'(read_data), 32'd0);
    check_eq({tag, "_is_empty"}, 32'(is_empty), 32'd1);
    check_eq({tag, "_is_full"}, 32'(is_full), 32'd0);
    check_eq({tag, "_fill_count"}, 32'(fill_count), 32'd0);
    check_eq({tag, "_write_error"}, 32'(write_error), 32'd0);
    check_eq({tag, "_read_error"}, 32'(read_error), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = '0;
    last_rd      = '0;
    #3;
    check_reset_state("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reads on an empty FIFO.
    rd();
    rd();
    step(1'b0, '0, 1'b0);

    // Basic fill and partial drain.
    wr(8'd1); wr(8'd2); wr(8'd3);
    rd(); rd();

    // Fill to full, overflow, then read.
    wr(8'd4); wr(8'd5); wr(8'd6);
    wr(8'd7);
    rd();

    // Overflow twice, then drain through pointer wrap and underflow twice.
    wr(8'd8);
    wr(8'd9); wr(8'd10);
    repeat (6) rd();

    wr(8'd11); wr(8'd12);
    repeat (3) rd();

    // Full with simultaneous read and write.
    wr(8'd20); wr(8'd21); wr(8'd22); wr(8'd23);
    step(1'b1, 8'd24, 1'b1);
    repeat (4) rd();

    // Empty with simultaneous read and write: no fall-through.
    step(1'b1, 8'd30, 1'b1);
    // Partially full with simultaneous read and write.
    step(1'b1, 8'd31, 1'b1);
    rd();

    // Reset mid-operation with three entries stored.
    wr(8'd40); wr(8'd41); wr(8'd42);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("mid_reset");
    model.delete();
    exp_rd.delete();
    last_rd = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    wr(8'd5);
    rd();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    while (model.size() != 0) rd();
    check_eq("final_scoreboard_empty", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
